// File: rtl/seg_pkg.sv
// Shared definitions for the segment FSM monitor: state codes, tracker states, step rules.
package seg_pkg;

  localparam int unsigned STATE_W    = 3;
  localparam int unsigned NUM_STATES = 5;

  // Upstream segment FSM state codes; 5..7 are illegal
  typedef enum logic [STATE_W-1:0] {
    ST_A = 3'd0,
    ST_B = 3'd1,
    ST_C = 3'd2,
    ST_D = 3'd3,
    ST_E = 3'd4
  } seg_state_e;

  // Monitor tracker FSM
  typedef enum logic [1:0] {
    T_IDLE,
    T_TRACK,
    T_TRAPPED,
    T_FAULT
  } trk_state_e;

  // Progress through a B -> C -> B loop
  typedef enum logic [1:0] {
    LP_NONE,
    LP_B,
    LP_BC
  } loop_ph_e;

  function automatic logic is_legal_code(input logic [STATE_W-1:0] code);
    return 32'(code) < NUM_STATES;
  endfunction

  function automatic logic is_legal_step(input logic [STATE_W-1:0] prev,
                                         input logic [STATE_W-1:0] nxt);
    logic ok;
    ok = 1'b0;
    case (prev)
      ST_A:    ok = (nxt == ST_A) || (nxt == ST_B);
      ST_B:    ok = (nxt == ST_C) || (nxt == ST_D);
      ST_C:    ok = (nxt == ST_B);
      ST_D:    ok = (nxt == ST_E);
      ST_E:    ok = (nxt == ST_E);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/seg_monitor_if.sv
// Sample input and status output bundle of the segment monitor.
interface seg_monitor_if
  import seg_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);
  logic               in_valid;
  logic [STATE_W-1:0] in_state;
  logic               clear;
  logic               trap;
  logic               err_code;
  logic               err_step;
  logic               err_first;
  logic [CNT_W-1:0]   loop_cnt;
  logic [CNT_W-1:0]   dwell_a;
  logic [CNT_W-1:0]   max_dwell_a;
  logic [CNT_W-1:0]   sample_cnt;
  trk_state_e         trk_state;   // tracker position, for the debug status bus

  modport master (
    output in_valid, in_state, clear,
    input  trap, err_code, err_step, err_first,
    input  loop_cnt, dwell_a, max_dwell_a, sample_cnt, trk_state
  );

  modport slave (
    input  in_valid, in_state, clear,
    output trap, err_code, err_step, err_first,
    output loop_cnt, dwell_a, max_dwell_a, sample_cnt, trk_state
  );
endinterface

// File: rtl/seg_sat_counter.sv
// Saturating up-counter with synchronous zero taking priority over increment.
module seg_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             zero,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: zero wins, increment stops at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (zero)
      cnt_d = '0;
    else if (inc && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  // Count register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign count = cnt_q;
endmodule

// File: rtl/seg_monitor.sv
// Checker downstream of the five-state segment FSM: step legality, trap entry,
// B-C-B loop counting and A dwell statistics.
module seg_monitor
  import seg_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic   clock,
  input  logic   reset_n,
  seg_monitor_if.slave bus
);
  trk_state_e         trk_q, trk_d;
  loop_ph_e           ph_q, ph_d;
  logic [STATE_W-1:0] prev_q, prev_d;
  logic               trap_q, trap_d;
  logic               ecode_q, ecode_d;
  logic               estep_q, estep_d;
  logic               efirst_q, efirst_d;
  logic [CNT_W-1:0]   max_q, max_d;
  logic [CNT_W-1:0]   dwell, dwell_nxt;
  logic               acc, is_a, code_ok, loop_inc, dwell_inc, dwell_zero;

  assign acc     = bus.in_valid && !bus.clear;
  assign code_ok = is_legal_code(bus.in_state);
  assign is_a    = (bus.in_state == ST_A);

  // Tracker next state, sticky flags and loop phase
  always_comb begin
    trk_d    = trk_q;
    ph_d     = ph_q;
    prev_d   = prev_q;
    trap_d   = trap_q;
    ecode_d  = ecode_q;
    estep_d  = estep_q;
    efirst_d = efirst_q;
    loop_inc = 1'b0;
    if (bus.clear) begin
      trk_d    = T_IDLE;
      ph_d     = LP_NONE;
      prev_d   = ST_A;
      trap_d   = 1'b0;
      ecode_d  = 1'b0;
      estep_d  = 1'b0;
      efirst_d = 1'b0;
    end else if (bus.in_valid) begin
      // The closing B of one loop is also the opening B of the next
      if (code_ok && bus.in_state == ST_B) begin
        loop_inc = (ph_q == LP_BC);
        ph_d     = LP_B;
      end else if (code_ok && bus.in_state == ST_C) begin
        ph_d = (ph_q == LP_B) ? LP_BC : LP_NONE;
      end else begin
        ph_d = LP_NONE;
      end

      if (!code_ok) begin
        ecode_d = 1'b1;
        trk_d   = T_FAULT;
      end else begin
        case (trk_q)
          T_IDLE: begin
            prev_d = bus.in_state;
            if (!is_a) efirst_d = 1'b1;
            if (bus.in_state == ST_E) begin
              trap_d = 1'b1;
              trk_d  = T_TRAPPED;
            end else begin
              trk_d = T_TRACK;
            end
          end
          T_TRACK: begin
            prev_d = bus.in_state;
            if (!is_legal_step(prev_q, bus.in_state)) begin
              estep_d = 1'b1;
              trk_d   = T_FAULT;
            end else if (bus.in_state == ST_E) begin
              trap_d = 1'b1;
              trk_d  = T_TRAPPED;
            end
          end
          T_TRAPPED: begin
            prev_d = bus.in_state;
            if (bus.in_state != ST_E) begin
              estep_d = 1'b1;
              trk_d   = T_FAULT;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Tracker and flag registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      trk_q    <= T_IDLE;
      ph_q     <= LP_NONE;
      prev_q   <= ST_A;
      trap_q   <= 1'b0;
      ecode_q  <= 1'b0;
      estep_q  <= 1'b0;
      efirst_q <= 1'b0;
    end else begin
      trk_q    <= trk_d;
      ph_q     <= ph_d;
      prev_q   <= prev_d;
      trap_q   <= trap_d;
      ecode_q  <= ecode_d;
      estep_q  <= estep_d;
      efirst_q <= efirst_d;
    end
  end

  assign dwell_inc  = acc && is_a;
  assign dwell_zero = bus.clear || (acc && !is_a);

  // Tracking the counter's next value keeps max_dwell_a level with a live A run
  always_comb begin
    dwell_nxt = dwell;
    if (dwell_zero)
      dwell_nxt = '0;
    else if (dwell_inc && (dwell != '1))
      dwell_nxt = dwell + 1'b1;
    max_d = max_q;
    if (bus.clear)
      max_d = '0;
    else if (dwell_nxt > max_q)
      max_d = dwell_nxt;
  end

  // Longest A run register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) max_q <= '0;
    else          max_q <= max_d;
  end

  seg_sat_counter #(.CNT_W(CNT_W)) u_sample_cnt (
    .clock(clock), .reset_n(reset_n), .inc(acc), .zero(bus.clear), .count(bus.sample_cnt)
  );

  seg_sat_counter #(.CNT_W(CNT_W)) u_loop_cnt (
    .clock(clock), .reset_n(reset_n), .inc(loop_inc), .zero(bus.clear), .count(bus.loop_cnt)
  );

  seg_sat_counter #(.CNT_W(CNT_W)) u_dwell_a (
    .clock(clock), .reset_n(reset_n), .inc(dwell_inc), .zero(dwell_zero), .count(dwell)
  );

  assign bus.dwell_a     = dwell;
  assign bus.max_dwell_a = max_q;
  assign bus.trap        = trap_q;
  assign bus.err_code    = ecode_q;
  assign bus.err_step    = estep_q;
  assign bus.err_first   = efirst_q;
  assign bus.trk_state   = trk_q;
endmodule

// File: doc/seg_monitor.md
# seg_monitor

Sequential checker that sits directly downstream of the five-state segment FSM (states A..E) and consumes its per-cycle state code. It tracks the FSM's position, enforces the legal successor relation, detects entry into the absorbing state E, and counts B->C->B loop iterations and A dwell time. Its sticky flags and counters feed the property layer and the debug status bus.

## Interface
- CNT_W, 16: width of every counter; all counters saturate at 2^CNT_W-1.
- STATE_W, 3: width of the state code; codes 0..4 = A..E, and 5..7 are illegal.
- clock  in  1  single clock; all state changes on the posedge.
- reset_n  in  1  reset, asynchronous and active-low; clears all state and outputs.
- in_valid  in  1  in_state holds a sample this cycle.
- in_state  in  STATE_W  upstream FSM state code.
- clear  in  1  synchronous clear of flags and counters; the tracker returns to IDLE.
- trap  out  1  sticky; E has been entered.
- err_code  out  1  sticky; a sample with code > 4 was seen.
- err_step  out  1  sticky; an illegal successor was seen.
- err_first  out  1  sticky; the first sample after reset or clear was not A.
- loop_cnt  out  CNT_W  count of completed B->C->B loops.
- dwell_a  out  CNT_W  length of the current consecutive-A run.
- max_dwell_a  out  CNT_W  longest A run so far.
- sample_cnt  out  CNT_W  count of accepted samples.

## Operation
- Legal successors: A->{A,B}; B->{C,D}; C->{B}; D->{E}; E->{E}.
- Tracker FSM states and transitions:
  - IDLE: no sample accepted yet. The first valid sample moves to TRACK, or to FAULT if the code is illegal.
  - TRACK: each sample is checked against the previous sample (prev). Entry to E moves to TRAPPED.
  - TRAPPED: only E is legal. Any other code sets err_step and moves to FAULT.
  - FAULT: terminal until reset or clear. Counters keep counting; flags stay set.
- First sample:
  - code 0 leaves err_first = 0.
  - Any other legal code sets err_first, and checking continues from that code.
- Illegal code:
  - Sets err_code and moves to FAULT.
  - prev is not updated.
  - The next sample is not step-checked.
- loop_cnt increments when the sequence B, C, B completes. The second B counts and also starts the next loop, so B C B C B gives 2.
- dwell_a behaviour:
  - Increments on each A sample.
  - On a non-A sample, it first updates max_dwell_a = max(max_dwell_a, dwell_a), then resets to 0.
  - max_dwell_a also compares against the live dwell_a every cycle, so it never lags a running A streak.
- in_valid low: nothing changes and nothing is checked. Gaps are transparent to step checking.
- Simultaneous clear and in_valid: clear wins and the sample is discarded.

## Timing
- All outputs are registered and update on the posedge after the accepting cycle, giving 1-cycle latency from sample to flag or counter.
- Reset values: every flag 0, every counter 0, tracker FSM in IDLE, prev = A.
- reset_n asserted mid-operation: all outputs clear asynchronously within the same cycle. The first valid sample after deassertion is treated as the first sample.
- Saturation: counters stop at all-ones and do not wrap. A saturated dwell_a still feeds max_dwell_a correctly.
- Flags are never cleared by traffic, only by reset_n or clear.

## Structure
- Shared package seg_pkg holds:
  - the state codes A..E, NUM_STATES = 5 and STATE_W;
  - the tracker state encoding (IDLE, TRACK, TRAPPED, FAULT);
  - the pure function is_legal_step(prev, next).
- Sub-module seg_sat_counter (width CNT_W, inputs inc and zero, output saturating count) is instantiated for loop_cnt, dwell_a and sample_cnt.
- max_dwell_a and the tracker FSM live in seg_monitor.

## Test plan
- Legal path, after reset: A A A B C B C B D E E. Required: loop_cnt=2, max_dwell_a=3, trap=1, sample_cnt=11, and all err flags 0.
- Illegal step: A B A. Required: err_step=1 one cycle after the third sample, tracker in FAULT, and trap=0.
- First sample not A: first sample C, then B. Required: err_first=1 and err_step=0.
- Illegal code: A then code 6 then B. Required: err_code=1, err_step=0, and sample_cnt=3.
- Saturation with CNT_W=4: 20 consecutive A samples. Required: dwell_a=15, max_dwell_a=15, sample_cnt=15.
- Reset and clear cases:
  - reset_n pulsed low mid-stream: all outputs are 0 immediately.
  - clear asserted together with in_valid carrying code 0: the sample is ignored and sample_cnt=0 on the next cycle.
